atm_session_ctrl: RTL and testbench
===================================

// Module: atm_session_ctrl
// PURPOSE
//   Parametrised ATM session controller: card scan, PIN check with retry limit and card retention,
//   withdraw/deposit/balance ops on an internal balance register, idle timeout.
//   Sits between the front-panel input decoder and the cash dispenser / display driver.
//   Replaces the fixed 4-bit PIN / 8-bit amount controller and keeps its one-hot status style.
// PARAMETERS
//   PIN_W      4     PIN width, bits
//   AMT_W      8     amount and balance width, bits
//   MAX_TRIES  3     wrong PINs allowed before retention (1..7)
//   TIMEOUT    1000  idle cycles in PIN/OPSEL/MORE before abort (>=2)
//   DAY_LIM    200   per-session withdraw limit (used only with ATM_DAILY_LIMIT_EN)
// PORTS
//   clk        in   1      clock, all logic on posedge
//   rst        in   1      synchronous reset, active-high
//   card_in    in   1      card inserted (level)
//   card_ok    in   1      scan complete and good (1-cycle strobe)
//   pin_vld    in   1      pin_in valid this cycle
//   pin_in     in   PIN_W  entered PIN
//   pin_ref    in   PIN_W  stored PIN of scanned card
//   bal_ld     in   1      load bal_init into balance (accepted in IDLE only)
//   bal_init   in   AMT_W  initial balance
//   op_vld     in   1      op/amt_in valid this cycle
//   op         in   2      01 balance, 10 withdraw, 11 deposit, 00 illegal
//   amt_in     in   AMT_W  amount for op
//   more       in   1      in MORE: 1 = another op, 0 = end (sampled with op_vld)
//   status     out  10     one-hot: IDLE,SCAN,PIN,OPSEL,WDRAW,DEPO,BAL,MORE,ERR,RETAIN
//   balance    out  AMT_W  current balance register
//   disp_vld   out  1      1-cycle strobe: dispense disp_amt
//   disp_amt   out  AMT_W  amount to dispense, valid with disp_vld
//   err_code   out  3      0 none,1 bad PIN,2 insufficient,3 overflow,4 illegal op,5 timeout,6 limit
//   tries_left out  3      remaining PIN attempts
// BEHAVIOUR
//   Reset: state IDLE, status=IDLE one-hot, balance=0, disp_vld=0, disp_amt=0, err_code=0,
//     tries_left=MAX_TRIES, timer=0. Reset wins over every other input in the same cycle.
//   Registered Moore FSM; all outputs registered; one decision per cycle, 1-cycle input-to-output.
//   IDLE: bal_ld -> balance<=bal_init. card_in -> SCAN.
//   SCAN: card_ok -> PIN (tries_left<=MAX_TRIES); card_in=0 -> IDLE; else hold.
//   PIN: pin_vld & pin_in==pin_ref -> OPSEL. pin_vld & mismatch: tries_left-1; if it reaches 0 -> RETAIN,
//     else stay PIN, err_code=1 for that cycle.
//   OPSEL (on op_vld): 01->BAL; 10->WDRAW; 11->DEPO; 00->ERR(err 4).
//   WDRAW: amt_in<=balance -> balance-=amt_in, disp_vld=1, disp_amt=amt_in, ->MORE; else ERR(err 2).
//     amt_in==0 accepted, disp_vld still pulses with disp_amt=0.
//   DEPO: compute AMT_W+1 sum; carry=1 -> ERR(err 3), balance unchanged; else balance<=sum, ->MORE.
//   BAL: one cycle, balance shown, ->MORE.
//   MORE: op_vld&more -> OPSEL; op_vld&!more -> IDLE.
//   ERR: one cycle, err_code held, -> MORE (session continues; bad-PIN is handled in PIN).
//   RETAIN: card kept; stays until card_in=0 for one cycle AND rst... no: exits to IDLE only on rst.
//   Timer: counts in PIN/OPSEL/MORE while no *_vld; clears on any state change or vld.
//     Reaching TIMEOUT-1 -> IDLE, err_code=5 for one cycle.
//   card_in dropping in any state except IDLE/RETAIN -> IDLE next cycle, no balance change.
//   err_code clears to 0 on entering any state other than ERR/RETAIN unless set by that transition.
// CONFIGURATION
//   ATM_DAILY_LIMIT_EN defined: withdrawn-this-session accumulator (AMT_W+1 bits, clears in IDLE);
//     WDRAW also requires acc+amt_in<=DAY_LIM, else ERR(err 6), no debit.
//   Undefined: no accumulator, DAY_LIM ignored, err 6 never produced.
// STRUCTURE
//   Package atm_pkg: state enum, status bit indices, err_code constants, op encodings.
//   One sub-module atm_timeout_cnt (parametrised TIMEOUT, clear/enable in, expire out).
// TESTING
//   Reset, card_in, card_ok, correct PIN 4'hA, bal_init=100, op 10 amt 40 -> disp 40, balance 60.
//   Three wrong PINs -> tries_left 2,1 then RETAIN, err 1; only rst returns to IDLE.
//   balance 250, deposit 10 -> ERR err 3, balance stays 250; deposit 5 -> 255.
//   balance 30, withdraw 31 -> err 2, no disp_vld; withdraw 30 -> balance 0.
//   OPSEL idle TIMEOUT cycles -> IDLE, err 5; rst asserted mid-WDRAW -> IDLE, balance 0, no disp.
//   With ATM_DAILY_LIMIT_EN, DAY_LIM 50: withdraw 30 ok, then 30 -> err 6, balance unchanged.
```

Correction to the RETAIN line above, which is to be read as: "RETAIN: card kept; exits to IDLE only on rst; card_in ignored."

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM session controller: one-hot state
// encoding (doubles as the status word), error codes and operation encodings.
package atm_pkg;

  localparam int ST_W = 10;

  localparam int IDLE_BIT   = 0;
  localparam int SCAN_BIT   = 1;
  localparam int PIN_BIT    = 2;
  localparam int OPSEL_BIT  = 3;
  localparam int WDRAW_BIT  = 4;
  localparam int DEPO_BIT   = 5;
  localparam int BAL_BIT    = 6;
  localparam int MORE_BIT   = 7;
  localparam int ERR_BIT    = 8;
  localparam int RETAIN_BIT = 9;

  // One-hot values so the state register can drive the status port directly.
  typedef enum logic [ST_W-1:0] {
    S_IDLE   = ST_W'(1 << IDLE_BIT),
    S_SCAN   = ST_W'(1 << SCAN_BIT),
    S_PIN    = ST_W'(1 << PIN_BIT),
    S_OPSEL  = ST_W'(1 << OPSEL_BIT),
    S_WDRAW  = ST_W'(1 << WDRAW_BIT),
    S_DEPO   = ST_W'(1 << DEPO_BIT),
    S_BAL    = ST_W'(1 << BAL_BIT),
    S_MORE   = ST_W'(1 << MORE_BIT),
    S_ERR    = ST_W'(1 << ERR_BIT),
    S_RETAIN = ST_W'(1 << RETAIN_BIT)
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PIN     = 3'd1;
  localparam logic [2:0] ERR_FUNDS   = 3'd2;
  localparam logic [2:0] ERR_OVF     = 3'd3;
  localparam logic [2:0] ERR_OP      = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [2:0] ERR_LIMIT   = 3'd6;

  localparam logic [1:0] OP_ILLEGAL = 2'b00;
  localparam logic [1:0] OP_BAL     = 2'b01;
  localparam logic [1:0] OP_WDRAW   = 2'b10;
  localparam logic [1:0] OP_DEPO    = 2'b11;

  // States in which the controller waits on the customer and the idle timer runs.
  function automatic logic is_timed(input state_t s);
    return (s == S_PIN) || (s == S_OPSEL) || (s == S_MORE);
  endfunction

endpackage

// File: rtl/atm_timeout_cnt.sv
// Idle-cycle counter: counts while enabled, clears on request, flags the
// cycle in which the count has reached TIMEOUT-1.
module atm_timeout_cnt #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign expire = en && (cnt == LAST);

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= expire ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card scan, PIN retry/retention, withdraw/deposit/
// balance ops and idle timeout. ATM_DAILY_LIMIT_EN adds a per-session withdraw cap.
module atm_session_ctrl #(
  parameter int PIN_W     = 4,
  parameter int AMT_W     = 8,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 1000,
  parameter int DAY_LIM   = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_in,
  input  logic             card_ok,
  input  logic             pin_vld,
  input  logic [PIN_W-1:0] pin_in,
  input  logic [PIN_W-1:0] pin_ref,
  input  logic             bal_ld,
  input  logic [AMT_W-1:0] bal_init,
  input  logic             op_vld,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt_in,
  input  logic             more,
  output logic [9:0]       status,
  output logic [AMT_W-1:0] balance,
  output logic             disp_vld,
  output logic [AMT_W-1:0] disp_amt,
  output logic [2:0]       err_code,
  output logic [2:0]       tries_left
);

  import atm_pkg::*;

  if (MAX_TRIES < 1 || MAX_TRIES > 7 || TIMEOUT < 2 || DAY_LIM < 0) begin : g_param_check
    $error("atm_session_ctrl: parameter out of range");
  end

  state_t           state;
  logic [AMT_W-1:0] amt_q;
  logic [AMT_W:0]   dep_sum;
  logic             timed;
  logic             any_vld;
  logic             tmr_en;
  logic             expire;

  assign status  = state;
  assign dep_sum = {1'b0, balance} + {1'b0, amt_q};
  assign timed   = is_timed(state);
  assign any_vld = (state == S_PIN) ? pin_vld : op_vld;
  assign tmr_en  = timed && !any_vld;

  atm_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (!tmr_en),
    .en     (tmr_en),
    .expire (expire)
  );

`ifdef ATM_DAILY_LIMIT_EN
  localparam int LIM_W = AMT_W + 2;
  logic [AMT_W:0]   acc;
  logic [LIM_W-1:0] lim_sum;
  assign lim_sum = {1'b0, acc} + {2'b00, amt_q};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      balance    <= '0;
      disp_vld   <= 1'b0;
      disp_amt   <= '0;
      err_code   <= ERR_NONE;
      tries_left <= 3'(MAX_TRIES);
      amt_q      <= '0;
`ifdef ATM_DAILY_LIMIT_EN
      acc        <= '0;
`endif
    end else begin
      disp_vld <= 1'b0;
      err_code <= ERR_NONE;
      if (!card_in && state != S_IDLE && state != S_RETAIN) begin
        state <= S_IDLE;
      end else if (expire) begin
        state    <= S_IDLE;
        err_code <= ERR_TIMEOUT;
      end else begin
        case (state)
          S_IDLE: begin
            if (bal_ld) balance <= bal_init;
            if (card_in) state <= S_SCAN;
`ifdef ATM_DAILY_LIMIT_EN
            acc <= '0;
`endif
          end
          S_SCAN: begin
            if (card_ok) begin
              state      <= S_PIN;
              tries_left <= 3'(MAX_TRIES);
            end
          end
          S_PIN: begin
            if (pin_vld) begin
              if (pin_in == pin_ref) begin
                state <= S_OPSEL;
              end else begin
                tries_left <= tries_left - 3'd1;
                err_code   <= ERR_PIN;
                if (tries_left == 3'd1) state <= S_RETAIN;
              end
            end
          end
          S_OPSEL: begin
            if (op_vld) begin
              amt_q <= amt_in;
              case (op)
                OP_BAL:   state <= S_BAL;
                OP_WDRAW: state <= S_WDRAW;
                OP_DEPO:  state <= S_DEPO;
                default: begin
                  state    <= S_ERR;
                  err_code <= ERR_OP;
                end
              endcase
            end
          end
          S_WDRAW: begin
            if (amt_q > balance) begin
              state    <= S_ERR;
              err_code <= ERR_FUNDS;
`ifdef ATM_DAILY_LIMIT_EN
            end else if (lim_sum > LIM_W'(DAY_LIM)) begin
              state    <= S_ERR;
              err_code <= ERR_LIMIT;
`endif
            end else begin
              balance  <= balance - amt_q;
              disp_vld <= 1'b1;
              disp_amt <= amt_q;
              state    <= S_MORE;
`ifdef ATM_DAILY_LIMIT_EN
              acc      <= lim_sum[AMT_W:0];
`endif
            end
          end
          S_DEPO: begin
            if (dep_sum[AMT_W]) begin
              state    <= S_ERR;
              err_code <= ERR_OVF;
            end else begin
              balance <= dep_sum[AMT_W-1:0];
              state   <= S_MORE;
            end
          end
          S_BAL:  state <= S_MORE;
          S_MORE: begin
            if (op_vld) state <= more ? S_OPSEL : S_IDLE;
          end
          S_ERR:  state <= S_MORE;
          // Card is kept and the bad-PIN code stays up until reset.
          S_RETAIN: err_code <= err_code;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Self-checking bench for atm_session_ctrl: directed session scenarios plus
// randomized front-panel traffic compared against a cycle-level behavioural model.
module tb_atm_session_ctrl;

  localparam int PIN_W     = 4;
  localparam int AMT_W     = 8;
  localparam int MAX_TRIES = 3;
  localparam int TIMEOUT   = 20;
  localparam int DAY_LIM   = 50;
  localparam int AMT_MAX   = (1 << AMT_W) - 1;

  // Model phases, numbered by their position in the status word.
  localparam int M_IDLE = 0, M_SCAN = 1, M_PIN = 2, M_OPSEL = 3, M_WDRAW = 4;
  localparam int M_DEPO = 5, M_BAL = 6, M_MORE = 7, M_ERR = 8, M_RETAIN = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             card_in;
  logic             card_ok;
  logic             pin_vld;
  logic [PIN_W-1:0] pin_in;
  logic [PIN_W-1:0] pin_ref;
  logic             bal_ld;
  logic [AMT_W-1:0] bal_init;
  logic             op_vld;
  logic [1:0]       op;
  logic [AMT_W-1:0] amt_in;
  logic             more;
  logic [9:0]       status;
  logic [AMT_W-1:0] balance;
  logic             disp_vld;
  logic [AMT_W-1:0] disp_amt;
  logic [2:0]       err_code;
  logic [2:0]       tries_left;

  int checks = 0;
  int errors = 0;

  int m_st, m_bal, m_da, m_err, m_tries, m_idle, m_amt, m_acc;
  bit m_dv;

  always #5 clk = ~clk;

  atm_session_ctrl #(
    .PIN_W(PIN_W), .AMT_W(AMT_W), .MAX_TRIES(MAX_TRIES),
    .TIMEOUT(TIMEOUT), .DAY_LIM(DAY_LIM)
  ) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_ok(card_ok),
    .pin_vld(pin_vld), .pin_in(pin_in), .pin_ref(pin_ref),
    .bal_ld(bal_ld), .bal_init(bal_init), .op_vld(op_vld), .op(op),
    .amt_in(amt_in), .more(more), .status(status), .balance(balance),
    .disp_vld(disp_vld), .disp_amt(disp_amt), .err_code(err_code),
    .tries_left(tries_left)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: one call per clock edge, using the inputs held across it.
  task automatic model_step();
    int nxt;
    int e;
    bit waiting;
    if (rst) begin
      m_st = M_IDLE; m_bal = 0; m_dv = 0; m_da = 0; m_err = 0;
      m_tries = MAX_TRIES; m_idle = 0; m_amt = 0; m_acc = 0;
      return;
    end
    nxt = m_st;
    e = 0;
    m_dv = 0;
    waiting = (m_st == M_PIN && !pin_vld) ||
              ((m_st == M_OPSEL || m_st == M_MORE) && !op_vld);
    if (m_st == M_IDLE) m_acc = 0;
    if (!card_in && m_st != M_IDLE && m_st != M_RETAIN) begin
      nxt = M_IDLE;
    end else if (waiting && m_idle == TIMEOUT - 1) begin
      nxt = M_IDLE;
      e = 5;
    end else begin
      case (m_st)
        M_IDLE: begin
          if (bal_ld) m_bal = int'(bal_init);
          if (card_in) nxt = M_SCAN;
        end
        M_SCAN: if (card_ok) begin nxt = M_PIN; m_tries = MAX_TRIES; end
        M_PIN: begin
          if (pin_vld) begin
            if (pin_in == pin_ref) nxt = M_OPSEL;
            else begin
              m_tries = m_tries - 1;
              e = 1;
              if (m_tries == 0) nxt = M_RETAIN;
            end
          end
        end
        M_OPSEL: begin
          if (op_vld) begin
            m_amt = int'(amt_in);
            case (op)
              2'b01: nxt = M_BAL;
              2'b10: nxt = M_WDRAW;
              2'b11: nxt = M_DEPO;
              default: begin nxt = M_ERR; e = 4; end
            endcase
          end
        end
        M_WDRAW: begin
          if (m_amt > m_bal) begin
            nxt = M_ERR; e = 2;
`ifdef ATM_DAILY_LIMIT_EN
          end else if (m_acc + m_amt > DAY_LIM) begin
            nxt = M_ERR; e = 6;
`endif
          end else begin
            m_bal = m_bal - m_amt;
            m_dv = 1;
            m_da = m_amt;
            m_acc = m_acc + m_amt;
            nxt = M_MORE;
          end
        end
        M_DEPO: begin
          if (m_bal + m_amt > AMT_MAX) begin nxt = M_ERR; e = 3; end
          else begin m_bal = m_bal + m_amt; nxt = M_MORE; end
        end
        M_BAL:    nxt = M_MORE;
        M_MORE:   if (op_vld) nxt = more ? M_OPSEL : M_IDLE;
        M_ERR:    nxt = M_MORE;
        M_RETAIN: e = m_err;
        default:  nxt = M_IDLE;
      endcase
    end
    m_idle = (waiting && nxt == m_st) ? m_idle + 1 : 0;
    m_st = nxt;
    m_err = e;
  endtask

  task automatic compare_all();
    check("status", 32'(status), 32'd1 << m_st);
    check("balance", 32'(balance), 32'(m_bal));
    check("disp_vld", 32'(disp_vld), 32'(m_dv));
    check("disp_amt", 32'(disp_amt), 32'(m_da));
    check("err_code", 32'(err_code), 32'(m_err));
    check("tries_left", 32'(tries_left), 32'(m_tries));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    rst = 1'b0; card_ok = 1'b0; pin_vld = 1'b0; bal_ld = 1'b0;
    op_vld = 1'b0; op = 2'b00; amt_in = '0; more = 1'b0; pin_in = '0;
  endtask

  task automatic do_reset();
    quiet();
    card_in = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic open_session(input int bal);
    quiet();
    card_in = 1'b1; bal_ld = 1'b1; bal_init = AMT_W'(bal);
    step();
    bal_ld = 1'b0; card_ok = 1'b1;
    step();
    card_ok = 1'b0; pin_ref = 4'hA; pin_in = 4'hA; pin_vld = 1'b1;
    step();
    pin_vld = 1'b0;
  endtask

  task automatic issue_op(input logic [1:0] o, input int amt);
    op_vld = 1'b1; op = o; amt_in = AMT_W'(amt);
    step();
    op_vld = 1'b0;
  endtask

  task automatic next_op();
    op_vld = 1'b1; more = 1'b1;
    step();
    op_vld = 1'b0;
  endtask

  initial begin
    quiet();
    card_in = 1'b0; pin_ref = 4'hA; bal_init = '0;

    // Reset state
    rst = 1'b1;
    step();
    check("rst_status", 32'(status), 32'h001);
    check("rst_tries", 32'(tries_left), 32'(MAX_TRIES));
    check("rst_balance", 32'(balance), 32'd0);
    rst = 1'b0;

    // Basic withdraw: 100 - 40
    open_session(100);
    check("sess_opsel", 32'(status), 32'h008);
    issue_op(2'b10, 40);
    step();
    check("wd40_disp_vld", 32'(disp_vld), 32'd1);
    check("wd40_disp_amt", 32'(disp_amt), 32'd40);
    check("wd40_balance", 32'(balance), 32'd60);
    step();
    check("wd40_disp_pulse", 32'(disp_vld), 32'd0);
    op_vld = 1'b1; more = 1'b0;
    step();
    op_vld = 1'b0;
    check("end_sess_idle", 32'(status), 32'h001);

    // Wrong PIN three times -> retention
    do_reset();
    card_in = 1'b1;
    step();
    card_ok = 1'b1;
    step();
    card_ok = 1'b0; pin_ref = 4'hA; pin_in = 4'h5; pin_vld = 1'b1;
    step();
    check("pin1_tries", 32'(tries_left), 32'd2);
    check("pin1_err", 32'(err_code), 32'd1);
    step();
    check("pin2_tries", 32'(tries_left), 32'd1);
    step();
    check("pin3_retain", 32'(status), 32'h200);
    check("pin3_err", 32'(err_code), 32'd1);
    pin_vld = 1'b0; card_in = 1'b0;
    repeat (5) step();
    check("retain_hold", 32'(status), 32'h200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("retain_rst", 32'(status), 32'h001);
    check("retain_rst_tries", 32'(tries_left), 32'(MAX_TRIES));

    // Deposit overflow then exact fill
    do_reset();
    open_session(250);
    issue_op(2'b11, 10);
    step();
    check("dep_ovf_state", 32'(status), 32'h100);
    check("dep_ovf_err", 32'(err_code), 32'd3);
    check("dep_ovf_bal", 32'(balance), 32'd250);
    step();
    check("err_to_more", 32'(status), 32'h080);
    check("err_cleared", 32'(err_code), 32'd0);
    next_op();
    issue_op(2'b11, 5);
    step();
    check("dep5_bal", 32'(balance), 32'd255);

    // Insufficient funds, exact debit, zero-amount withdraw
    do_reset();
    open_session(30);
    issue_op(2'b10, 31);
    step();
    check("wd31_err", 32'(err_code), 32'd2);
    check("wd31_no_disp", 32'(disp_vld), 32'd0);
    step();
    next_op();
    issue_op(2'b10, 30);
    step();
    check("wd30_bal", 32'(balance), 32'd0);
    check("wd30_disp", 32'(disp_amt), 32'd30);
    step();
    next_op();
    issue_op(2'b10, 0);
    step();
    check("wd0_disp_vld", 32'(disp_vld), 32'd1);
    check("wd0_disp_amt", 32'(disp_amt), 32'd0);

    // Illegal op and balance query
    next_op();
    issue_op(2'b00, 7);
    check("illegal_err", 32'(err_code), 32'd4);
    step();
    next_op();
    issue_op(2'b01, 0);
    check("bal_state", 32'(status), 32'h040);

    // Idle timeout in OPSEL
    do_reset();
    open_session(50);
    repeat (TIMEOUT - 1) step();
    check("tmo_before", 32'(status), 32'h008);
    step();
    check("tmo_idle", 32'(status), 32'h001);
    check("tmo_err", 32'(err_code), 32'd5);

    // Reset in the middle of a withdraw
    do_reset();
    open_session(100);
    issue_op(2'b10, 40);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_wd_idle", 32'(status), 32'h001);
    check("rst_wd_bal", 32'(balance), 32'd0);
    check("rst_wd_disp", 32'(disp_vld), 32'd0);

`ifdef ATM_DAILY_LIMIT_EN
    // Per-session limit: 30 ok, second 30 refused
    do_reset();
    open_session(100);
    issue_op(2'b10, 30);
    step();
    check("lim_wd1_bal", 32'(balance), 32'd70);
    next_op();
    issue_op(2'b10, 30);
    step();
    check("lim_err", 32'(err_code), 32'd6);
    check("lim_bal", 32'(balance), 32'd70);
    check("lim_no_disp", 32'(disp_vld), 32'd0);
`endif

    // Randomized front-panel traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      card_in  = ($urandom_range(0, 49) != 0);
      card_ok  = ($urandom_range(0, 3) == 0);
      pin_ref  = PIN_W'($urandom);
      pin_vld  = ($urandom_range(0, 2) == 0);
      pin_in   = ($urandom_range(0, 3) != 0) ? pin_ref : PIN_W'($urandom);
      bal_ld   = ($urandom_range(0, 4) == 0);
      bal_init = AMT_W'($urandom);
      op_vld   = ($urandom_range(0, 2) == 0);
      op       = 2'($urandom);
      amt_in   = ($urandom_range(0, 1) == 0) ? AMT_W'($urandom_range(0, 40)) : AMT_W'($urandom);
      more     = ($urandom_range(0, 4) != 0);
      step();
    end
    quiet();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
